// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared msrv32 data-memory encodings
// htrans codes, responder states and response constants.
package msrv32_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic OKAY  = 1'b0;
   localparam logic ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } dmem_state_t;

endpackage

// File: rtl/msrv32_dmem_array.sv
// rtl/msrv32_dmem_array.sv - word array with byte-lane writes
// Asynchronous read; contents are deliberately never reset.
module msrv32_dmem_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (we[n]) begin
            mem[addr][8*n +: 8] <= wdata[8*n +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - AHB-style data-memory slave for the msrv32 core
// Accepts an address phase, stalls WAIT_STATES cycles, then completes the data phase.
module msrv32_dmem_responder
   import msrv32_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic [31:0] ms_riscv32_mp_dmaddr_in,
   input  logic        ms_riscv32_mp_dmwr_req_in,
   input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
   input  logic [1:0]  ahb_htrans_in,
   input  logic [31:0] ms_riscv32_mp_dmdata_in,
   output logic        ahb_ready_out,
   output logic        ahb_resp_out,
   output logic [31:0] ms_riscv32_mp_dmdata_out
);

   dmem_state_t           state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_q;
   logic [3:0]            mask_q;
   logic                  accept;
   logic                  out_of_range;
   logic [3:0]            we;
   logic [31:0]           rdata;
   logic                  unused_addr_lsb;

   // Lane selection comes from the mask alone, so the byte offset is dropped.
   assign unused_addr_lsb = ^ms_riscv32_mp_dmaddr_in[1:0];

   assign ahb_ready_out = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
   assign ahb_resp_out  = ((state == ST_ERR1) || (state == ST_ERR2)) ? ERROR : OKAY;
   assign accept        = ahb_ready_out && ahb_htrans_in[1];
   assign out_of_range  = (ms_riscv32_mp_dmaddr_in >> (ADDR_WIDTH + 2)) != 32'd0;

   // Reset coinciding with DATA must not commit the write.
   assign we = (state == ST_DATA && wr_q && !ms_riscv32_mp_rst_in) ? mask_q : 4'b0000;

   assign ms_riscv32_mp_dmdata_out = (state == ST_DATA && !wr_q) ? rdata : 32'd0;

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         addr_q <= '0;
         wr_q   <= 1'b0;
         mask_q <= 4'b0000;
      end else begin
         case (state)
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= ST_DATA;
               end
            end
            ST_ERR1: state <= ST_ERR2;
            default: begin
               if (accept) begin
                  addr_q <= ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
                  wr_q   <= ms_riscv32_mp_dmwr_req_in;
                  mask_q <= ms_riscv32_mp_dmwr_mask_in;
                  if (out_of_range) begin
                     state <= ST_ERR1;
                  end else if (WAIT_STATES == 0) begin
                     state <= ST_DATA;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= 4'(WAIT_STATES);
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   msrv32_dmem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk   (ms_riscv32_mp_clk_in),
      .we    (we),
      .addr  (addr_q),
      .wdata (ms_riscv32_mp_dmdata_in),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - directed bench for msrv32_dmem_responder
// Three instances (1, 0 and 3 wait states) share stimulus; sel picks the active one.
module tb_msrv32_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = 32'd0;
   logic        wr = 1'b0;
   logic [3:0]  mask = 4'b0000;
   logic [1:0]  htrans = 2'b00;
   logic [31:0] wdata = 32'd0;
   int          sel = 0;

   logic [1:0]  ht_v [3];
   logic [2:0]  ready_v;
   logic [2:0]  resp_v;
   logic [31:0] rdata_v [3];
   logic        ready;
   logic        resp;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign ht_v[0] = (sel == 0) ? htrans : 2'b00;
   assign ht_v[1] = (sel == 1) ? htrans : 2'b00;
   assign ht_v[2] = (sel == 2) ? htrans : 2'b00;
   assign ready   = ready_v[sel];
   assign resp    = resp_v[sel];
   assign rdata   = rdata_v[sel];

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_ws1 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst),
      .ms_riscv32_mp_dmaddr_in    (addr),
      .ms_riscv32_mp_dmwr_req_in  (wr),
      .ms_riscv32_mp_dmwr_mask_in (mask),
      .ahb_htrans_in              (ht_v[0]),
      .ms_riscv32_mp_dmdata_in    (wdata),
      .ahb_ready_out              (ready_v[0]),
      .ahb_resp_out               (resp_v[0]),
      .ms_riscv32_mp_dmdata_out   (rdata_v[0])
   );

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst),
      .ms_riscv32_mp_dmaddr_in    (addr),
      .ms_riscv32_mp_dmwr_req_in  (wr),
      .ms_riscv32_mp_dmwr_mask_in (mask),
      .ahb_htrans_in              (ht_v[1]),
      .ms_riscv32_mp_dmdata_in    (wdata),
      .ahb_ready_out              (ready_v[1]),
      .ahb_resp_out               (resp_v[1]),
      .ms_riscv32_mp_dmdata_out   (rdata_v[1])
   );

   msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_ws3 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst),
      .ms_riscv32_mp_dmaddr_in    (addr),
      .ms_riscv32_mp_dmwr_req_in  (wr),
      .ms_riscv32_mp_dmwr_mask_in (mask),
      .ahb_htrans_in              (ht_v[2]),
      .ms_riscv32_mp_dmdata_in    (wdata),
      .ahb_ready_out              (ready_v[2]),
      .ahb_resp_out               (resp_v[2]),
      .ms_riscv32_mp_dmdata_out   (rdata_v[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transfer from an idle bus; returns read data and stall count.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] m,
                       input logic [31:0] d, output logic [31:0] rd, output int nwait);
      int guard;
      @(negedge clk);
      addr   = a;
      wr     = w;
      mask   = m;
      wdata  = d;
      htrans = 2'b10;
      @(posedge clk);
      #1 htrans = 2'b00;
      nwait = 0;
      guard = 0;
      rd    = 32'd0;
      @(negedge clk);
      while (ready !== 1'b1 && guard < 40) begin
         nwait++;
         guard++;
         @(negedge clk);
      end
      if (guard >= 40) check("xfer_timeout", 32'(guard), 32'd0);
      rd = rdata;
      @(posedge clk);
   endtask

   logic [31:0] rd;
   int          nw;

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #0;
         check("rst_ready", 32'(ready), 32'd1);
         check("rst_resp", 32'(resp), 32'd0);
         check("rst_rdata", rdata, 32'd0);
      end

      // Byte-masked write/read, one wait state
      sel = 0;
      xfer(32'h0000_0010, 1'b1, 4'b1111, 32'hABCD_EF01, rd, nw);
      check("ws1_wr_wait", 32'(nw), 32'd1);
      xfer(32'h0000_0010, 1'b1, 4'b0001, 32'h0000_00FF, rd, nw);
      check("ws1_wr2_wait", 32'(nw), 32'd1);
      xfer(32'h0000_0010, 1'b0, 4'b0000, 32'h0, rd, nw);
      check("ws1_rd_wait", 32'(nw), 32'd1);
      check("ws1_rd_data", rd, 32'hABCD_EFFF);

      // Pipelined write then read of the same word, zero wait states
      sel = 1;
      xfer(32'h0000_0020, 1'b1, 4'b1111, 32'h0, rd, nw);
      check("ws0_clr_wait", 32'(nw), 32'd0);
      @(negedge clk);
      addr = 32'h0000_0020; wr = 1'b1; mask = 4'b1100; wdata = 32'h1234_0000; htrans = 2'b10;
      @(negedge clk);
      check("ws0_wr_ready", 32'(ready), 32'd1);
      check("ws0_wr_rdata", rdata, 32'd0);
      wr = 1'b0; mask = 4'b0000; htrans = 2'b11;
      @(negedge clk);
      htrans = 2'b00;
      check("ws0_rd_ready", 32'(ready), 32'd1);
      check("ws0_rd_data", rdata, 32'h1234_0000);
      @(negedge clk);
      check("ws0_idle_rdata", rdata, 32'd0);

      // Out-of-range access must error and leave the aliased word alone
      sel = 0;
      xfer(32'h0000_0320, 1'b1, 4'b1111, 32'h5A5A_5A5A, rd, nw);
      @(negedge clk);
      addr = 32'h8765_4321; wr = 1'b1; mask = 4'b1111; wdata = 32'hFFFF_FFFF; htrans = 2'b10;
      @(negedge clk);
      htrans = 2'b00;
      check("err1_ready", 32'(ready), 32'd0);
      check("err1_resp", 32'(resp), 32'd1);
      check("err1_rdata", rdata, 32'd0);
      @(negedge clk);
      check("err2_ready", 32'(ready), 32'd1);
      check("err2_resp", 32'(resp), 32'd1);
      @(negedge clk);
      check("err_done_resp", 32'(resp), 32'd0);
      xfer(32'h0000_0320, 1'b0, 4'b0000, 32'h0, rd, nw);
      check("err_word_kept", rd, 32'h5A5A_5A5A);

      // Reset in the middle of a stalled write, three wait states
      sel = 2;
      xfer(32'h0000_0040, 1'b1, 4'b1111, 32'h1122_3344, rd, nw);
      check("ws3_wr_wait", 32'(nw), 32'd3);
      @(negedge clk);
      addr = 32'h0000_0040; wr = 1'b1; mask = 4'b1111; wdata = 32'hDEAD_BEEF; htrans = 2'b10;
      @(negedge clk);
      htrans = 2'b00;
      check("ws3_stall", 32'(ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("ws3_rst_ready", 32'(ready), 32'd1);
      check("ws3_rst_resp", 32'(resp), 32'd0);
      repeat (4) @(negedge clk);
      xfer(32'h0000_0040, 1'b0, 4'b0000, 32'h0, rd, nw);
      check("ws3_rd_wait", 32'(nw), 32'd3);
      check("ws3_rd_data", rd, 32'h1122_3344);

      // IDLE/BUSY must never start a transfer
      sel = 0;
      @(negedge clk);
      addr = 32'h0000_0010; wr = 1'b1; mask = 4'b1111; wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         htrans = (i % 2 == 0) ? 2'b00 : 2'b01;
         @(negedge clk);
         check("filt_ready", 32'(ready), 32'd1);
         check("filt_resp", 32'(resp), 32'd0);
      end
      htrans = 2'b00;
      xfer(32'h0000_0010, 1'b0, 4'b0000, 32'h0, rd, nw);
      check("filt_word_kept", rd, 32'hABCD_EFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
